mem_access_unit: RTL and testbench

- MEM-stage data-memory initiator for the 5-stage RV32 core.
- Accepts load/store ops from EX/MEM and issues one request per op on a valid/ready data bus.
- Waits for the response, formats load data, and produces mem_done / mem_read_data for the MEM/WB register.
- Holds mem_done until the pipeline advances (if_done && mem_done), so each op is issued exactly once across IF stalls.

---
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage initiator (master) and the memory side (slave).
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: one bus request per load/store, load formatting, mem_done hold.
// Optional macro MISALIGN_TRAP_EN: trap misaligned accesses instead of issuing them force-aligned.
module mem_access_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [4:0]  OP_LOAD  = 5'b00000,
  parameter logic [4:0]  OP_STORE = 5'b01000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_done,
  input  logic [4:0]  mem_op,
  input  logic [2:0]  mem_func3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_read_data,
  output logic        mem_misalign,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e            state_q, state_d;
  logic              req_valid_q, req_valid_d;
  logic              req_write_q, req_write_d;
  logic              resp_ready_q, resp_ready_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [3:0]        req_wstrb_q, req_wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        off_q, off_d;

  logic is_load, is_store, adv;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << off;
      3'b001:  s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] st_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  // Loads encode size in func3[1:0] (bit 2 is unsigned); stores only know SB/SH, the rest is word.
  function automatic logic misaligned(input logic ld, input logic [2:0] f3, input logic [1:0] off);
    logic half, word;
    if (ld) begin
      half = (f3[1:0] == 2'b01);
      word = f3[1];
    end else begin
      half = (f3 == 3'b001);
      word = (f3 != 3'b000) && (f3 != 3'b001);
    end
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction
`endif

  assign is_load  = (mem_op == OP_LOAD);
  assign is_store = (mem_op == OP_STORE);
  assign mem_done = (state_q == DONE) || ((state_q == IDLE) && !is_load && !is_store);
  assign adv      = if_done && mem_done;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    req_write_d  = req_write_q;
    resp_ready_d = resp_ready_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wstrb_d  = req_wstrb_q;
    rdata_d      = rdata_q;
    misalign_d   = misalign_q;
    func3_d      = func3_q;
    off_d        = off_q;

    case (state_q)
      IDLE: begin
        if (is_load || is_store) begin
          req_write_d = is_store;
          req_addr_d  = ADDR_W'({mem_addr[31:2], 2'b00});
          req_wdata_d = st_wdata(mem_func3, mem_wdata);
          req_wstrb_d = is_store ? st_strb(mem_func3, mem_addr[1:0]) : 4'b0000;
          func3_d     = mem_func3;
          off_d       = mem_addr[1:0];
`ifdef MISALIGN_TRAP_EN
          if (misaligned(is_load, mem_func3, mem_addr[1:0])) begin
            misalign_d = 1'b1;
            rdata_d    = 32'h0;
            state_d    = DONE;
          end else begin
            req_valid_d = 1'b1;
            state_d     = REQ;
          end
`else
          req_valid_d = 1'b1;
          state_d     = REQ;
`endif
        end
      end
      REQ: begin
        if (bus.req_ready) begin
          req_valid_d  = 1'b0;
          resp_ready_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (bus.resp_valid) begin
          resp_ready_d = 1'b0;
          if (!req_write_q) rdata_d = fmt_load(func3_q, off_q, bus.resp_rdata);
          state_d = DONE;
        end
      end
      DONE: begin
        if (adv) begin
          misalign_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= 32'h0;
      req_wstrb_q  <= 4'b0000;
      rdata_q      <= 32'h0;
      misalign_q   <= 1'b0;
      func3_q      <= 3'b000;
      off_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_write_q  <= req_write_d;
      resp_ready_q <= resp_ready_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_wstrb_q  <= req_wstrb_d;
      rdata_q      <= rdata_d;
      misalign_q   <= misalign_d;
      func3_q      <= func3_d;
      off_q        <= off_d;
    end
  end

  assign bus.req_valid  = req_valid_q;
  assign bus.req_write  = req_write_q;
  assign bus.req_addr   = req_addr_q;
  assign bus.req_wdata  = req_wdata_q;
  assign bus.req_wstrb  = req_wstrb_q;
  assign bus.resp_ready = resp_ready_q;
  assign mem_read_data  = rdata_q;
  assign mem_misalign   = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: bus slave model with programmable stalls.
module tb_mem_access_unit;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_ALU   = 5'b01100;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_done;
  logic [4:0]  mem_op;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_done, mem_misalign;
  logic [31:0] mem_read_data;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE)) dut (
    .clk(clk), .rst(rst), .if_done(if_done), .mem_op(mem_op), .mem_func3(mem_func3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
    .mem_read_data(mem_read_data), .mem_misalign(mem_misalign), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  req_t        exp_req_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] last_rd;

  int          req_delay, resp_delay, ready_wait, resp_wait;
  bit          resp_pend, req_hs_flag, resp_hs_flag, stall_prev;
  logic [31:0] slave_rdata;
  int          hs_cnt = 0;
  req_t        snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] bsh, hsh;
    bsh = w >> (8 * a[1:0]);
    hsh = w >> (16 * a[1]);
    case (f3)
      3'b000:  return {{24{bsh[7]}}, bsh[7:0]};
      3'b100:  return {24'h0, bsh[7:0]};
      3'b001:  return {{16{hsh[15]}}, hsh[15:0]};
      3'b101:  return {16'h0, hsh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic req_t model_req(input logic [4:0] op, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.w = (op == OP_STORE);
    r.a = a & 32'hFFFF_FFFC;
    r.d = wd;
    r.s = 4'b0000;
    if (r.w) begin
      if (f3 == 3'b000) begin
        r.d = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        r.s = 4'b0001 << a[1:0];
      end else if (f3 == 3'b001) begin
        r.d = {wd[15:0], wd[15:0]};
        r.s = a[1] ? 4'b1100 : 4'b0011;
      end else begin
        r.s = 4'b1111;
      end
    end
    return r;
  endfunction

  // Handshake monitor: pops the expected request, checks stability during stalls.
  always @(posedge clk) begin
    req_t e;
    if (!rst) begin
      if (bus.req_valid) begin
        if (stall_prev) begin
          check("req_stable_addr",  bus.req_addr,  snap.a);
          check("req_stable_wdata", bus.req_wdata, snap.d);
          check("req_stable_wstrb", {28'h0, bus.req_wstrb}, {28'h0, snap.s});
        end
        snap       = '{w: bus.req_write, a: bus.req_addr, d: bus.req_wdata, s: bus.req_wstrb};
        stall_prev = !bus.req_ready;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) begin
        hs_cnt++;
        req_hs_flag = 1'b1;
        if (exp_req_q.size() == 0) begin
          check("req_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_req_q.pop_front();
          check("req_write", {31'h0, bus.req_write}, {31'h0, e.w});
          check("req_addr",  bus.req_addr, e.a);
          check("req_wstrb", {28'h0, bus.req_wstrb}, {28'h0, e.s});
          if (e.w) check("req_wdata", bus.req_wdata, e.d);
        end
      end
      if (bus.resp_valid && bus.resp_ready) resp_hs_flag = 1'b1;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Bus slave: req_ready after req_delay stall cycles, resp_valid resp_delay cycles after the handshake.
  initial begin
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_rdata = 32'h0;
    resp_pend = 0; req_hs_flag = 0; resp_hs_flag = 0; ready_wait = 0; resp_wait = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
        resp_pend = 0; req_hs_flag = 0; resp_hs_flag = 0;
        ready_wait = req_delay;
      end else begin
        if (resp_hs_flag) begin resp_hs_flag = 0; bus.resp_valid = 1'b0; end
        if (req_hs_flag) begin
          req_hs_flag = 0; bus.req_ready = 1'b0; resp_pend = 1; resp_wait = resp_delay;
        end
        if (!bus.req_valid) ready_wait = req_delay;
        else if (!bus.req_ready) begin
          if (ready_wait == 0) bus.req_ready = 1'b1;
          else ready_wait--;
        end
        if (resp_pend) begin
          if (resp_wait == 0) begin
            bus.resp_valid = 1'b1; bus.resp_rdata = slave_rdata; resp_pend = 0;
          end else resp_wait--;
        end
      end
    end
  end

  task automatic do_op(input string tag, input logic [4:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int rdly, input int sdly, input int hold, input bit trap);
    logic [31:0] exp_rd;
    int lat, hs0;
    bit done;
    @(posedge clk); #1;
    req_delay = rdly; resp_delay = sdly; slave_rdata = rd;
    if (!trap) exp_req_q.push_back(model_req(op, f3, a, wd));
    exp_rd = trap ? 32'h0 : (op == OP_LOAD) ? model_load(f3, a, rd) : last_rd;
    exp_rd_q.push_back(exp_rd);
    hs0 = hs_cnt;
    if_done = (hold == 0);
    mem_op = op; mem_func3 = f3; mem_addr = a; mem_wdata = wd;
    lat = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      done = mem_done;
    end
    check({tag, " done"}, {31'h0, done}, 32'd1);
    check({tag, " latency"}, lat, trap ? 1 : 3 + rdly + sdly);
    check({tag, " rdata"}, mem_read_data, exp_rd_q.pop_front());
    check({tag, " misalign"}, {31'h0, mem_misalign}, {31'h0, trap});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold done"}, {31'h0, mem_done}, 32'd1);
      check({tag, " hold rdata"}, mem_read_data, exp_rd);
      check({tag, " hold no req"}, {31'h0, bus.req_valid}, 32'd0);
    end
    if_done = 1'b1;
    @(posedge clk); #1;
    mem_op = OP_ALU;
    #1;
    check({tag, " adv idle"}, {31'h0, mem_done}, 32'd1);
    check({tag, " adv misalign"}, {31'h0, mem_misalign}, 32'd0);
    check({tag, " handshakes"}, hs_cnt - hs0, trap ? 0 : 1);
    last_rd = exp_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; if_done = 1'b1; mem_op = OP_ALU; mem_func3 = 3'b000;
    mem_addr = 32'h0; mem_wdata = 32'h0; req_delay = 0; resp_delay = 0;
    slave_rdata = 32'h0; last_rd = 32'h0; stall_prev = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst req_valid",  {31'h0, bus.req_valid},  32'd0);
    check("rst req_write",  {31'h0, bus.req_write},  32'd0);
    check("rst resp_ready", {31'h0, bus.resp_ready}, 32'd0);
    check("rst req_addr",   bus.req_addr,  32'h0);
    check("rst req_wdata",  bus.req_wdata, 32'h0);
    check("rst req_wstrb",  {28'h0, bus.req_wstrb}, 32'h0);
    check("rst rdata",      mem_read_data, 32'h0);
    check("rst misalign",   {31'h0, mem_misalign}, 32'd0);
    check("rst alu done",   {31'h0, mem_done}, 32'd1);
    rst = 1'b0;

    do_op("lb",  OP_LOAD,  3'b000, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 0, 0, 0);
    do_op("sh",  OP_STORE, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h5555_5555, 0, 0, 0, 0);
    do_op("lw",  OP_LOAD,  3'b010, 32'h0000_0040, 32'h0,         32'h1234_5678, 4, 2, 0, 0);
    do_op("lhu", OP_LOAD,  3'b101, 32'h0000_0006, 32'h0,         32'hA5A5_C3C3, 0, 0, 5, 0);
    do_op("sb",  OP_STORE, 3'b000, 32'h0000_0301, 32'h1234_56AB, 32'h0,         0, 0, 0, 0);
    do_op("lh",  OP_LOAD,  3'b001, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 1, 0, 0, 0);
    do_op("lbu", OP_LOAD,  3'b100, 32'h0000_0001, 32'h0,         32'h0000_9A00, 0, 1, 0, 0);
    do_op("sw",  OP_STORE, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1, 1, 0, 0);

    // Reset while the unit waits for a response.
    @(posedge clk); #1;
    req_delay = 0; resp_delay = 6; slave_rdata = 32'h7777_7777;
    exp_req_q.push_back(model_req(OP_LOAD, 3'b010, 32'h80, 32'h0));
    mem_op = OP_LOAD; mem_func3 = 3'b010; mem_addr = 32'h80;
    n = 0;
    while (n < 20 && !bus.resp_ready) begin @(posedge clk); #1; n++; end
    check("rstmid in resp", {31'h0, bus.resp_ready}, 32'd1);
    rst = 1'b1; mem_op = OP_ALU;
    @(posedge clk); #1;
    check("rstmid req_valid",  {31'h0, bus.req_valid},  32'd0);
    check("rstmid resp_ready", {31'h0, bus.resp_ready}, 32'd0);
    check("rstmid req_addr",   bus.req_addr,  32'h0);
    check("rstmid req_wstrb",  {28'h0, bus.req_wstrb}, 32'h0);
    check("rstmid rdata",      mem_read_data, 32'h0);
    rst = 1'b0; last_rd = 32'h0;
    @(posedge clk); #1;
    check("rstmid alu done", {31'h0, mem_done}, 32'd1);
    check("rstmid no req",   {31'h0, bus.req_valid}, 32'd0);
    do_op("post_rst lb", OP_LOAD, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_0042, 0, 0, 0, 0);

`ifdef MISALIGN_TRAP_EN
    do_op("lw_mis", OP_LOAD, 3'b010, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 1);
    do_op("sh_mis", OP_STORE, 3'b001, 32'h0000_0203, 32'h1234, 32'h0, 0, 0, 2, 1);
`else
    do_op("lw_mis", OP_LOAD, 3'b010, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
